// File: rtl/qtest_pkg.sv
// Shared types and default geometry for the on-chip memory self-test master.
// The state encoding and error-counter width live here so the top and the checker agree.
package qtest_pkg;

    localparam int DEF_DEPTH  = 128;
    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 8;

    localparam int                ERR_W   = 8;
    localparam logic [ERR_W-1:0]  ERR_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/qtest_mem_master_if.sv
// Avalon-MM port bundle between the test master and an on-chip memory slave
// with a fixed read latency of one cycle.
interface qtest_mem_master_if import qtest_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic [ADDR_W-1:0] m_address;
    logic              m_clken;
    logic              m_chipselect;
    logic              m_write;
    logic [DATA_W-1:0] m_writedata;
    logic [DATA_W-1:0] m_readdata;

    modport master (
        output m_address, m_clken, m_chipselect, m_write, m_writedata,
        input  m_readdata
    );

    modport slave (
        input  m_address, m_clken, m_chipselect, m_write, m_writedata,
        output m_readdata
    );

endinterface

// File: rtl/qtest_rd_checker.sv
// Read-side checker: delays the issued read address by the memory latency,
// compares returned data with the seed pattern and tracks errors.
module qtest_rd_checker import qtest_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              clear,
    input  logic              kill,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [DATA_W-1:0] seed_q,
    input  logic [DATA_W-1:0] readdata,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              err_free_next
);

    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    logic              mismatch;

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        mismatch      = pend_valid && (readdata != (DATA_W'(pend_addr) ^ seed_q));
        err_free_next = (err_count == '0) && !mismatch;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pend_valid     <= 1'b0;
            pend_addr      <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else if (clear) begin
            pend_valid     <= 1'b0;
            pend_addr      <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else if (kill) begin
            // An aborted test drops its in-flight read; totals so far are kept.
            pend_valid <= 1'b0;
        end else begin
            pend_valid <= issue_valid;
            pend_addr  <= issue_addr;
            if (mismatch) begin
                if (err_count != ERR_MAX)
                    err_count <= err_count + 1'b1;
                if (err_count == '0)
                    first_err_addr <= pend_addr;
            end
        end
    end

endmodule

// File: rtl/qtest_mem_master.sv
// Memory self-test master: writes addr^seed to every word, reads all words back,
// and reports a saturating mismatch count plus the first failing address.
module qtest_mem_master import qtest_pkg::*; #(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic [DATA_W-1:0]   seed,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERR_W-1:0]    err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    qtest_mem_master_if.master  mem
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] next_addr;
    logic [DATA_W-1:0] seed_q;
    logic              running;
    logic              accept;
    logic              kill;
    logic              err_free_next;

    assign running   = (state == S_WRITE) || (state == S_READ) || (state == S_DRAIN);
    assign accept    = !running && start;
    assign kill      = running && abort;
    assign next_addr = addr_cnt + 1'b1;

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                   input logic [DATA_W-1:0] s);
        return DATA_W'(a) ^ s;
    endfunction

    qtest_rd_checker #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rd_checker (
        .clk_clk        (clk_clk),
        .reset_reset_n  (reset_reset_n),
        .clear          (accept),
        .kill           (kill),
        .issue_valid    (mem.m_chipselect && !mem.m_write),
        .issue_addr     (mem.m_address),
        .seed_q         (seed_q),
        .readdata       (mem.m_readdata),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .err_free_next  (err_free_next)
    );

    // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state            <= S_IDLE;
            addr_cnt         <= '0;
            seed_q           <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            mem.m_address    <= '0;
            mem.m_clken      <= 1'b0;
            mem.m_chipselect <= 1'b0;
            mem.m_write      <= 1'b0;
            mem.m_writedata  <= '0;
        end else if (accept) begin
            state            <= S_WRITE;
            addr_cnt         <= '0;
            seed_q           <= seed;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            mem.m_address    <= '0;
            mem.m_clken      <= 1'b1;
            mem.m_chipselect <= 1'b1;
            mem.m_write      <= 1'b1;
            mem.m_writedata  <= pattern('0, seed);
        end else if (kill) begin
            // Abort outranks any same-cycle phase change; addr_cnt keeps its value.
            state            <= S_IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            mem.m_address    <= '0;
            mem.m_clken      <= 1'b0;
            mem.m_chipselect <= 1'b0;
            mem.m_write      <= 1'b0;
            mem.m_writedata  <= '0;
        end else begin
            case (state)
                S_WRITE: begin
                    if (addr_cnt == LAST_ADDR) begin
                        state           <= S_READ;
                        addr_cnt        <= '0;
                        mem.m_address   <= '0;
                        mem.m_write     <= 1'b0;
                        mem.m_writedata <= '0;
                    end else begin
                        addr_cnt        <= next_addr;
                        mem.m_address   <= next_addr;
                        mem.m_writedata <= pattern(next_addr, seed_q);
                    end
                end
                S_READ: begin
                    if (addr_cnt == LAST_ADDR) begin
                        // Clock enable stays on one more cycle so the last read word is registered.
                        state            <= S_DRAIN;
                        mem.m_chipselect <= 1'b0;
                        mem.m_address    <= '0;
                    end else begin
                        addr_cnt      <= next_addr;
                        mem.m_address <= next_addr;
                    end
                end
                S_DRAIN: begin
                    state       <= S_DONE;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    pass        <= err_free_next;
                    mem.m_clken <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
